list_builder: RTL and testbench
===============================

LIST_BUILDER -- requirements
Module: list_builder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-003 SHALL have ports: in_ptr  in  Width  element pointer; in_vld  in  1  element valid; in_last  in  1  element ends current list; in_rdy  out  1  element accepted when in_vld&in_rdy.
REQ-004 SHALL have ports: we  out  1  table write strobe; wa  out  Width  write address (element); wd  out  Width  next pointer (0 = end of list).
REQ-005 SHALL have ports: start  out  Width  committed list head; start_vld  out  1  head available; start_rdy  in  1  head popped when start_vld&start_rdy.
REQ-006 SHALL have ports: err_zero  out  1  sticky, zero pointer received; err_dup  out  1  sticky, pointer reused; list_cnt  out  8  lists committed, wraps mod 256.
REQ-007 SHALL have parameters: n, default 16, table entries; HeadDepth, default 4, head FIFO depth.

Function
REQ-008 SHALL implement FSM states IDLE (no list open), OPEN (prev held), TERM (terminator write pending).
REQ-009 SHALL drive in_rdy = 0 in TERM, 0 in IDLE when head FIFO is full, 1 otherwise.
REQ-010 SHALL, in IDLE, on accept of p!=0: latch cur_head=p; if in_last, issue write (p,0), increment list_cnt, stay IDLE; else prev=p, go OPEN.
REQ-011 SHALL, in OPEN, on accept of p!=0: issue write (prev,p), prev=p; if in_last, go TERM, else stay OPEN.
REQ-012 SHALL, in TERM, issue write (prev,0), increment list_cnt, go IDLE; this cycle accepts no input.
REQ-013 SHALL present each write on registered we/wa/wd exactly one cycle after the accepting edge; we is high for exactly one cycle per write.
REQ-014 SHALL push cur_head into the head FIFO on the edge after the cycle in which the terminator write (wd=0) is on we; start_vld rises in that next cycle, never earlier.
REQ-015 SHALL reserve the FIFO slot at list start, so a commit never finds the FIFO full; simultaneous push and pop leaves occupancy unchanged.
REQ-016 SHALL output start as the oldest FIFO entry, with start_vld = FIFO not empty; pop order is commit order.
REQ-017 SHALL, on accept of in_ptr=0: issue no write and set err_zero; in OPEN with in_last, go TERM; in IDLE, ignore in_last.
REQ-018 SHALL keep an n-bit used bitmap set on every element accepted; accepting an already-used pointer sets err_dup and still processes the element normally.
REQ-019 SHALL ignore in_ptr/in_last when in_vld=0, and SHALL ignore start_rdy when start_vld=0.

Reset
REQ-020 SHALL, on rst: state=IDLE, we=0, wa=0, wd=0, head FIFO empty (start_vld=0, start=0), used bitmap cleared, err_zero=0, err_dup=0, list_cnt=0.
REQ-021 SHALL discard a partially built list on reset mid-operation; no terminator write is issued for it.

Structure
REQ-022 SHALL take n, Width=$clog2(n) and typedef Pointer from the shared linked-list package, together with the list readers.
REQ-023 SHALL implement the head FIFO as the sub-module head_fifo (Pointer entries, depth HeadDepth, push/pop/full/empty).

Verification
REQ-024 Stream 7,15,8(last) -> writes (7,15),(15,8),(8,0) on consecutive we cycles; start=7 valid the cycle after (8,0); list_cnt=1.
REQ-025 Single 6(last), then immediately 2,4(last) -> writes (6,0),(2,4),(4,0); no stall after 6; FIFO order 6 then 2.
REQ-026 start_rdy=0, five one-element lists 1..5 -> in_rdy low after the fourth list starts; pulse start_rdy once -> 1 popped, list 5 accepted.
REQ-027 Stream 9,0,14(last) -> writes (9,14),(14,0); err_zero=1 and stays set.
REQ-028 Stream 3(last) then 3(last) -> err_dup=1; both (3,0) writes issued.
REQ-029 Assert rst after 1,5 accepted -> all outputs at reset values; following 10(last) -> write (10,0) only, head 10.

Source files
------------

// File: rtl/list_builder_pkg.sv
// Shared linked-list definitions used by the list builder and the list readers:
// table size, pointer type and builder FSM encoding.
package list_builder_pkg;
    localparam int unsigned n = 16;
    localparam int unsigned Width = $clog2(n);

    typedef logic [Width-1:0] Pointer;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        TERM = 2'd2
    } lb_state_e;

    localparam Pointer NullPtr = '0;
endpackage

// File: rtl/list_builder_head_fifo.sv
// Small FIFO holding the heads of committed lists, oldest entry shown on head.
module head_fifo
    import list_builder_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  Pointer push_data,
    input  logic   pop,
    output Pointer head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);
    localparam logic [CW-1:0] DepthC = CW'(Depth);

    Pointer        mem [Depth];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DepthC);
    assign empty   = (count == '0);
    // stale storage is masked so an empty FIFO always presents a null head
    assign head    = empty ? NullPtr : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_idx <= (wr_idx == LastIdx) ? '0 : wr_idx + 1'b1;
            if (do_pop)  rd_idx <= (rd_idx == LastIdx) ? '0 : rd_idx + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/list_builder.sv
// Builds singly linked lists in an external next-pointer table from a stream of
// element pointers and queues the head of each completed list for consumers.
//
// state | meaning
// IDLE  | no list open
// OPEN  | list open, prev holds last element
// TERM  | terminator write (prev,0) pending
module list_builder
    import list_builder_pkg::*;
#(
    parameter int unsigned n         = 16,
    parameter int unsigned HeadDepth = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  Pointer     in_ptr,
    input  logic       in_vld,
    input  logic       in_last,
    output logic       in_rdy,
    output logic       we,
    output Pointer     wa,
    output Pointer     wd,
    output Pointer     start,
    output logic       start_vld,
    input  logic       start_rdy,
    output logic       err_zero,
    output logic       err_dup,
    output logic [7:0] list_cnt
);
    localparam int unsigned SW = $clog2(HeadDepth + 1);
    localparam logic [SW-1:0] SlotMax = SW'(HeadDepth);

    lb_state_e      state;
    Pointer         cur_head;
    Pointer         prev;
    Pointer         push_head;
    logic           push_pend;
    logic [n-1:0]   used;
    logic [SW-1:0]  slots;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept;
    logic           list_start;
    logic           pop;

    // slots counts queued heads plus lists already started, so a commit never
    // finds the FIFO full
    always_comb begin
        in_rdy = 1'b1;
        if (state == TERM)
            in_rdy = 1'b0;
        else if (state == IDLE && (slots >= SlotMax || fifo_full))
            in_rdy = 1'b0;
    end

    assign accept     = in_vld && in_rdy;
    assign list_start = accept && (state == IDLE) && (in_ptr != NullPtr);
    assign start_vld  = !fifo_empty;
    assign pop        = start_vld && start_rdy;

    head_fifo #(.Depth(HeadDepth)) u_head_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pend),
        .push_data (push_head),
        .pop       (pop),
        .head      (start),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we        <= 1'b0;
            wa        <= NullPtr;
            wd        <= NullPtr;
            cur_head  <= NullPtr;
            prev      <= NullPtr;
            push_head <= NullPtr;
            push_pend <= 1'b0;
            used      <= '0;
            slots     <= '0;
            err_zero  <= 1'b0;
            err_dup   <= 1'b0;
            list_cnt  <= 8'd0;
        end else begin
            we        <= 1'b0;
            push_pend <= 1'b0;

            if (accept) begin
                used[in_ptr] <= 1'b1;
                if (used[in_ptr])        err_dup  <= 1'b1;
                if (in_ptr == NullPtr)   err_zero <= 1'b1;
            end

            case ({list_start, pop})
                2'b10:   slots <= slots + 1'b1;
                2'b01:   slots <= slots - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (list_start) begin
                        cur_head <= in_ptr;
                        if (in_last) begin
                            we        <= 1'b1;
                            wa        <= in_ptr;
                            wd        <= NullPtr;
                            list_cnt  <= list_cnt + 8'd1;
                            push_pend <= 1'b1;
                            push_head <= in_ptr;
                        end else begin
                            prev  <= in_ptr;
                            state <= OPEN;
                        end
                    end
                end
                OPEN: begin
                    if (accept) begin
                        if (in_ptr != NullPtr) begin
                            we   <= 1'b1;
                            wa   <= prev;
                            wd   <= in_ptr;
                            prev <= in_ptr;
                        end
                        if (in_last) state <= TERM;
                    end
                end
                TERM: begin
                    we        <= 1'b1;
                    wa        <= prev;
                    wd        <= NullPtr;
                    list_cnt  <= list_cnt + 8'd1;
                    push_pend <= 1'b1;
                    push_head <= cur_head;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_list_builder.sv
// Directed bench for list_builder: table writes, head queue order/timing,
// back-pressure, error flags and reset behaviour.
module tb_list_builder;
    import list_builder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    Pointer     in_ptr;
    logic       in_vld;
    logic       in_last;
    logic       in_rdy;
    logic       we;
    Pointer     wa;
    Pointer     wd;
    Pointer     start;
    logic       start_vld;
    logic       start_rdy;
    logic       err_zero;
    logic       err_dup;
    logic [7:0] list_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int w;
    int t;
    int sv_cyc;

    int wa_q[$];
    int wd_q[$];
    int wt_q[$];

    list_builder #(.n(16), .HeadDepth(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ptr    (in_ptr),
        .in_vld    (in_vld),
        .in_last   (in_last),
        .in_rdy    (in_rdy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .start     (start),
        .start_vld (start_vld),
        .start_rdy (start_rdy),
        .err_zero  (err_zero),
        .err_dup   (err_dup),
        .list_cnt  (list_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(int'(wa));
            wd_q.push_back(int'(wd));
            wt_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wt_q.delete();
    endtask

    task automatic chk_write(input string tag, input int idx, input int a, input int d);
        chk({tag, "_wa"}, (idx < wa_q.size()) ? wa_q[idx] : -1, a);
        chk({tag, "_wd"}, (idx < wd_q.size()) ? wd_q[idx] : -1, d);
    endtask

    // drive one element; returns the number of cycles spent waiting for in_rdy
    task automatic send(input logic [3:0] p, input logic l, output int waited);
        int k;
        k = 0;
        in_ptr  = p;
        in_last = l;
        in_vld  = 1'b1;
        @(negedge clk);
        while (!in_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("send_rdy", (k < 50), 1);
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        waited  = k;
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        int k;
        k = 0;
        while (!start_vld && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_vld"}, start_vld, 1);
        chk(tag, start, exp);
        start_rdy = 1'b1;
        @(posedge clk);
        #1;
        start_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_ptr = '0; in_last = 1'b0; start_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_start_vld", start_vld, 0);
        chk("rst_start", start, 0);
        chk("rst_err_zero", err_zero, 0);
        chk("rst_err_dup", err_dup, 0);
        chk("rst_list_cnt", list_cnt, 0);
        chk("rst_in_rdy", in_rdy, 1);
        @(posedge clk); #1; rst = 1'b0;

        // duplicate pointer: 3(last), 3(last)
        clear_log();
        send(4'd3, 1'b1, w);
        chk("dup_first_clean", err_dup, 0);
        send(4'd3, 1'b1, w);
        chk("dup_second_nostall", w, 0);
        repeat (4) @(negedge clk);
        chk("dup_flag", err_dup, 1);
        chk("dup_nwrites", wa_q.size(), 2);
        chk_write("dup_w0", 0, 3, 0);
        chk_write("dup_w1", 1, 3, 0);
        chk("dup_cnt", list_cnt, 2);
        pop_expect("dup_head0", 4'd3);
        pop_expect("dup_head1", 4'd3);
        chk("dup_drained", start_vld, 0);

        // 7,15,8(last): consecutive writes, head valid the cycle after (8,0)
        clear_log();
        send(4'd7, 1'b0, w);
        send(4'd15, 1'b0, w);
        send(4'd8, 1'b1, w);
        t = 0;
        while (!start_vld && t < 20) begin
            @(negedge clk);
            t++;
        end
        sv_cyc = cyc;
        chk("s1_nwrites", wa_q.size(), 3);
        chk_write("s1_w0", 0, 7, 15);
        chk_write("s1_w1", 1, 15, 8);
        chk_write("s1_w2", 2, 8, 0);
        chk("s1_consec01", (wt_q.size() == 3) ? wt_q[1] - wt_q[0] : -1, 1);
        chk("s1_consec12", (wt_q.size() == 3) ? wt_q[2] - wt_q[1] : -1, 1);
        chk("s1_vld_timing", (wt_q.size() == 3) ? sv_cyc - wt_q[2] : -1, 1);
        chk("s1_head", start, 7);
        chk("s1_cnt", list_cnt, 3);
        pop_expect("s1_pop", 4'd7);
        chk("s1_drained", start_vld, 0);

        // 6(last) then 2,4(last) with no stall between
        clear_log();
        send(4'd6, 1'b1, w);
        send(4'd2, 1'b0, w);
        chk("s2_no_stall", w, 0);
        send(4'd4, 1'b1, w);
        repeat (4) @(negedge clk);
        chk("s2_nwrites", wa_q.size(), 3);
        chk_write("s2_w0", 0, 6, 0);
        chk_write("s2_w1", 1, 2, 4);
        chk_write("s2_w2", 2, 4, 0);
        chk("s2_cnt", list_cnt, 5);
        pop_expect("s2_head0", 4'd6);
        pop_expect("s2_head1", 4'd2);

        // head FIFO back-pressure with start_rdy held low
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b1, w);
        in_ptr = 4'd5; in_last = 1'b1; in_vld = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_stalled", in_rdy, 0);
        chk("bp_head", start, 1);
        start_rdy = 1'b1;
        @(posedge clk); #1;
        start_rdy = 1'b0;
        t = 0;
        @(negedge clk);
        while (!in_rdy && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("bp_resume", in_rdy, 1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        for (int i = 2; i <= 5; i++) pop_expect("bp_order", 4'(i));
        chk("bp_cnt", list_cnt, 10);

        // zero pointer inside a list: 9,0,14(last)
        clear_log();
        send(4'd9, 1'b0, w);
        send(4'd0, 1'b0, w);
        send(4'd14, 1'b1, w);
        repeat (4) @(negedge clk);
        chk("z_nwrites", wa_q.size(), 2);
        chk_write("z_w0", 0, 9, 14);
        chk_write("z_w1", 1, 14, 0);
        chk("z_flag", err_zero, 1);
        repeat (5) @(negedge clk);
        chk("z_sticky", err_zero, 1);
        chk("z_cnt", list_cnt, 11);
        pop_expect("z_head", 4'd9);

        // reset with list 1,5 open: discarded, then 10(last) alone
        send(4'd1, 1'b0, w);
        send(4'd5, 1'b0, w);
        clear_log();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_we", we, 0);
        chk("mr_wa", wa, 0);
        chk("mr_wd", wd, 0);
        chk("mr_start_vld", start_vld, 0);
        chk("mr_start", start, 0);
        chk("mr_err_zero", err_zero, 0);
        chk("mr_err_dup", err_dup, 0);
        chk("mr_cnt", list_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;
        send(4'd10, 1'b1, w);
        repeat (4) @(negedge clk);
        chk("mr_nwrites", wa_q.size(), 1);
        chk_write("mr_w0", 0, 10, 0);
        chk("mr_cnt_after", list_cnt, 1);
        chk("mr_dup_after", err_dup, 0);
        pop_expect("mr_head", 4'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
